// File: rtl/arbitro_somador.sv
// arbitro_somador: two requesters share one N-bit adder; the N+1-bit sum lands in a one-entry output register.
// Latency: operands accepted in cycle t give res_valid/res_data at t+1. Backpressure: both readies drop while the register is full and res_ready is low.
// Tie-break: round-robin when ARBITRO_SOMADOR_RR_EN is defined, otherwise requester 0 has fixed priority.

module somador #(
    parameter int N = 64
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N:0]   res
);
    assign res = {1'b0, a} + {1'b0, b};
endmodule

module arbitro_somador #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         req1_ready,
    output logic         res_valid,
    output logic [N:0]   res_data,
    output logic         res_id,
    input  logic         res_ready
);

    logic         accept;
    logic         grant0;
    logic         grant1;
    logic         xfer0;
    logic         xfer1;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic [N:0]   sum;

`ifdef ARBITRO_SOMADOR_RR_EN
    // Index of the requester that won the most recent transfer.
    logic last;
`endif

    assign accept = !res_valid || res_ready;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef ARBITRO_SOMADOR_RR_EN
            grant0 = last;
            grant1 = !last;
`else
            grant0 = 1'b1;
`endif
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    // Readies stay low during reset so nothing is accepted into a register being cleared.
    assign req0_ready = grant0 && accept && !reset;
    assign req1_ready = grant1 && accept && !reset;
    assign xfer0      = req0_valid && req0_ready;
    assign xfer1      = req1_valid && req1_ready;

    always_comb begin
        op_a = '0;
        op_b = '0;
        if (xfer0) begin
            op_a = req0_a;
            op_b = req0_b;
        end else if (xfer1) begin
            op_a = req1_a;
            op_b = req1_b;
        end
    end

    somador #(.N(N)) u_somador (
        .a   (op_a),
        .b   (op_b),
        .res (sum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= 1'b0;
`ifdef ARBITRO_SOMADOR_RR_EN
            last      <= 1'b1;
`endif
        end else if (xfer0 || xfer1) begin
            res_valid <= 1'b1;
            res_data  <= sum;
            res_id    <= xfer1;
`ifdef ARBITRO_SOMADOR_RR_EN
            last      <= xfer1;
`endif
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arbitro_somador.sv
// Bench for arbitro_somador: tests drive and check readies inline, a negedge monitor checks results against a scoreboard queue.
module tb_arbitro_somador;
    localparam int N = 64;

    logic         clk;
    logic         reset;
    logic         req0_valid;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic         req0_ready;
    logic         req1_valid;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic         req1_ready;
    logic         res_valid;
    logic [N:0]   res_data;
    logic         res_id;
    logic         res_ready;

    int compared = 0;
    int mismatched = 0;

    logic [N+1:0] q[$];
    bit           exp_full = 0;
    bit           exp_zero = 0;
    bit           mon_en = 0;
    bit           pushed_now = 0;

    arbitro_somador #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_ready  (res_ready)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Result monitor: outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            compared++;
            if (res_valid !== exp_full) begin
                mismatched++;
                $display("FAIL res_valid: got %b expected %b at %0t", res_valid, exp_full, $time);
            end
            if (exp_full && q.size() > 0) begin
                compared++;
                if ({res_id, res_data} !== q[0]) begin
                    mismatched++;
                    $display("FAIL result: got id=%b data=%h expected id=%b data=%h at %0t",
                             res_id, res_data, q[0][N+1], q[0][N:0], $time);
                end
            end else if (exp_zero) begin
                compared++;
                if ({res_id, res_data} !== '0) begin
                    mismatched++;
                    $display("FAIL reset_value: got id=%b data=%h expected 0 at %0t", res_id, res_data, $time);
                end
            end
        end
        if (reset) begin
            q.delete();
            exp_full   = 0;
            exp_zero   = 1;
            mon_en     = 1;
            pushed_now = 0;
        end else if (mon_en) begin
            if (exp_full && res_ready) begin
                void'(q.pop_front());
                exp_full = 0;
            end
            if (pushed_now) begin
                exp_full   = 1;
                exp_zero   = 0;
                pushed_now = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input bit id, input logic [N:0] sum);
        q.push_back({id, sum});
        pushed_now = 1;
    endtask

    function automatic logic [N:0] add(input logic [N-1:0] a, input logic [N-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic test_reset();
        reset = 1; res_ready = 1;
        req0_valid = 1; req0_a = 64'd3; req0_b = 64'd4;
        req1_valid = 1; req1_a = 64'd1; req1_b = 64'd1;
        repeat (2) begin
            #2;
            compared++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                mismatched++;
                $display("FAIL ready_in_reset: got %b%b expected 00", req0_ready, req1_ready);
            end
            cyc();
        end
        reset = 0; req0_valid = 0; req1_valid = 0;
        repeat (2) begin
            #2;
            compared++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                mismatched++;
                $display("FAIL ready_idle: got %b%b expected 00", req0_ready, req1_ready);
            end
            cyc();
        end
    endtask

    task automatic test_single();
        req0_valid = 1; req0_a = 64'd5; req0_b = 64'd7; res_ready = 1;
        #2;
        compared++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            mismatched++;
            $display("FAIL single_ready: got %b%b expected 10", req0_ready, req1_ready);
        end
        push_exp(1'b0, 65'd12);
        cyc();
        req0_valid = 0;
        cyc();
    endtask

    task automatic test_carry();
        req1_valid = 1; req1_a = '1; req1_b = '1; res_ready = 1;
        #2;
        compared++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            mismatched++;
            $display("FAIL carry_ready: got %b%b expected 01", req0_ready, req1_ready);
        end
        push_exp(1'b1, 65'h1_FFFF_FFFF_FFFF_FFFE);
        cyc();
        req1_valid = 0;
    endtask

    // Entry state: last transfer came from requester 1, so round-robin starts with 0.
    task automatic test_tie();
        bit g;
        req0_valid = 1; req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom};
        req1_valid = 1; req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom};
        res_ready = 1;
        for (int i = 0; i < 6; i++) begin
`ifdef ARBITRO_SOMADOR_RR_EN
            g = i[0];
`else
            g = 1'b0;
`endif
            #2;
            compared++;
            if ({req0_ready, req1_ready} !== {!g, g}) begin
                mismatched++;
                $display("FAIL tie_grant[%0d]: got %b%b expected %b%b", i, req0_ready, req1_ready, !g, g);
            end
            if (g) push_exp(1'b1, add(req1_a, req1_b));
            else   push_exp(1'b0, add(req0_a, req0_b));
            cyc();
            if (g) begin req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom}; end
            else   begin req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom}; end
        end
        req0_valid = 0; req1_valid = 0;
    endtask

    // Register holds the last tie result; round-robin pointer now favours requester 0.
    task automatic test_backpressure();
        res_ready = 0;
        req0_valid = 1; req0_a = 64'h0123_4567_89AB_CDEF; req0_b = 64'h1111_1111_1111_1111;
        req1_valid = 1; req1_a = 64'd100; req1_b = 64'd200;
        repeat (3) begin
            #2;
            compared++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                mismatched++;
                $display("FAIL stall_ready: got %b%b expected 00", req0_ready, req1_ready);
            end
            cyc();
        end
        res_ready = 1;
        #2;
        compared++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            mismatched++;
            $display("FAIL refill_ready: got %b%b expected 10", req0_ready, req1_ready);
        end
        push_exp(1'b0, 65'h0_1234_5678_9ABC_DF00);
        cyc();
        req0_valid = 0; req1_valid = 0;
    endtask

    // Last transfer was from requester 0; only a reset of the pointer lets 0 win the next tie.
    task automatic test_reset_stall();
        res_ready = 0;
        req0_valid = 1; req0_a = 64'd9;  req0_b = 64'd10;
        req1_valid = 1; req1_a = 64'd20; req1_b = 64'd22;
        #2;
        compared++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            mismatched++;
            $display("FAIL full_stall_ready: got %b%b expected 00", req0_ready, req1_ready);
        end
        cyc();
        reset = 1;
        #2;
        compared++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            mismatched++;
            $display("FAIL midreset_ready: got %b%b expected 00", req0_ready, req1_ready);
        end
        cyc();
        reset = 0; res_ready = 1;
        #2;
        compared++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            mismatched++;
            $display("FAIL post_reset_grant: got %b%b expected 10", req0_ready, req1_ready);
        end
        push_exp(1'b0, 65'd19);
        cyc();
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic test_back_to_back();
        res_ready = 1;
        for (int i = 0; i < 4; i++) begin
            bit who = i[0];
            req0_valid = !who; req1_valid = who;
            req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom};
            req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom};
            #2;
            compared++;
            if ({req0_ready, req1_ready} !== {!who, who}) begin
                mismatched++;
                $display("FAIL b2b_ready[%0d]: got %b%b expected %b%b", i, req0_ready, req1_ready, !who, who);
            end
            if (who) push_exp(1'b1, add(req1_a, req1_b));
            else     push_exp(1'b0, add(req0_a, req0_b));
            cyc();
        end
        req0_valid = 0; req1_valid = 0;
        repeat (3) cyc();
    endtask

    initial begin
        reset = 1; res_ready = 1;
        req0_valid = 0; req0_a = '0; req0_b = '0;
        req1_valid = 0; req1_a = '0; req1_b = '0;
        test_reset();
        test_single();
        test_carry();
        test_tie();
        test_backpressure();
        test_reset_stall();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
